// File: rtl/mtf_decode.sv
// Move-to-front decoder: literal/index tokens in, decoded bytes out, 4-entry recency list.
// Optional per-token-type statistics counters are enabled by defining MTF_DECODE_STATS_EN.
module mtf_decode (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tok_valid_in,
    input  logic       tok_is_index_in,
    input  logic [7:0] tok_data_in,
    output logic       tok_ready_out,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_ready_in,
    output logic       err_out,
    output logic [2:0] list_count_out
`ifdef MTF_DECODE_STATS_EN
    ,
    output logic [15:0] lit_cnt_out,
    output logic [15:0] idx_cnt_out,
    output logic [15:0] err_cnt_out
`endif
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned COUNT_W = 3;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0]   entry_q [DEPTH];
    logic [DATA_W-1:0]   entry_d [DEPTH];

    logic                ready_c;
    logic                accept_c;
    logic                good_c;
    logic                bad_c;
    logic                hit_c;
    logic [1:0]          hit_pos_c;
    logic [1:0]          shift_pos_c;
    logic [1:0]          k_c;
    logic [DATA_W-1:0]   sel_byte_c;

`ifdef MTF_DECODE_STATS_EN
    localparam int unsigned STAT_W = 16;
    logic [STAT_W-1:0] lit_cnt_q, lit_cnt_d;
    logic [STAT_W-1:0] idx_cnt_q, idx_cnt_d;
    logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    // Token lookup, list update and output FSM, all from pre-edge list state.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        err_d       = 1'b0;
        count_d     = count_q;
        entry_d     = entry_q;
        hit_c       = 1'b0;
        hit_pos_c   = 2'd3;

        ready_c     = !rst_in && ((state_q == S_EMPTY) || data_ready_in);
        accept_c    = tok_valid_in && ready_c;
        k_c         = tok_data_in[1:0];

        // Descending scan so the lowest matching valid position wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((COUNT_W'(i) < count_q) && (entry_q[2'(i)] == tok_data_in)) begin
                hit_c     = 1'b1;
                hit_pos_c = 2'(i);
            end
        end

        good_c      = accept_c && (!tok_is_index_in || ({1'b0, k_c} < count_q));
        bad_c       = accept_c && tok_is_index_in && !({1'b0, k_c} < count_q);
        shift_pos_c = tok_is_index_in ? k_c : hit_pos_c;
        sel_byte_c  = tok_is_index_in ? entry_q[k_c] : tok_data_in;

        if (good_c) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (2'(i) <= shift_pos_c) begin
                    entry_d[2'(i)] = entry_q[2'(i - 1)];
                end
            end
            entry_d[0] = sel_byte_c;
            data_d     = sel_byte_c;
            if (!tok_is_index_in && !hit_c && (count_q != COUNT_W'(DEPTH))) begin
                count_d = count_q + COUNT_W'(1);
            end
        end

        err_d = bad_c;

        case (state_q)
            S_EMPTY: if (good_c) state_d = S_FULL;
            S_FULL:  if (data_ready_in && !good_c) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

`ifdef MTF_DECODE_STATS_EN
    always_comb begin
        lit_cnt_d = lit_cnt_q;
        idx_cnt_d = idx_cnt_q;
        err_cnt_d = err_cnt_q;
        if (good_c && !tok_is_index_in && (lit_cnt_q != '1)) lit_cnt_d = lit_cnt_q + STAT_W'(1);
        if (good_c && tok_is_index_in && (idx_cnt_q != '1))  idx_cnt_d = idx_cnt_q + STAT_W'(1);
        if (bad_c && (err_cnt_q != '1))                      err_cnt_d = err_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lit_cnt_q <= '0;
            idx_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            lit_cnt_q <= lit_cnt_d;
            idx_cnt_q <= idx_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign lit_cnt_out = lit_cnt_q;
    assign idx_cnt_out = idx_cnt_q;
    assign err_cnt_out = err_cnt_q;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
        end
    end

    assign tok_ready_out  = ready_c;
    assign data_out       = data_q;
    assign data_out_valid = (state_q == S_FULL);
    assign err_out        = err_q;
    assign list_count_out = count_q;

endmodule

// File: tb/tb_mtf_decode.sv
// Directed bench for mtf_decode: hand-computed outputs and recency-list contents after each step.
module tb_mtf_decode;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        tok_valid_in;
    logic        tok_is_index_in;
    logic [7:0]  tok_data_in;
    logic        tok_ready_out;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_ready_in;
    logic        err_out;
    logic [2:0]  list_count_out;
`ifdef MTF_DECODE_STATS_EN
    logic [15:0] lit_cnt_out;
    logic [15:0] idx_cnt_out;
    logic [15:0] err_cnt_out;
`endif

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;

    mtf_decode dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tok_valid_in    (tok_valid_in),
        .tok_is_index_in (tok_is_index_in),
        .tok_data_in     (tok_data_in),
        .tok_ready_out   (tok_ready_out),
        .data_out        (data_out),
        .data_out_valid  (data_out_valid),
        .data_ready_in   (data_ready_in),
        .err_out         (err_out),
        .list_count_out  (list_count_out)
`ifdef MTF_DECODE_STATS_EN
        ,
        .lit_cnt_out     (lit_cnt_out),
        .idx_cnt_out     (idx_cnt_out),
        .err_cnt_out     (err_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_list(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        chk({tag, "_e0"}, 16'(dut.entry_q[0]), 16'(e0));
        chk({tag, "_e1"}, 16'(dut.entry_q[1]), 16'(e1));
        chk({tag, "_e2"}, 16'(dut.entry_q[2]), 16'(e2));
        chk({tag, "_e3"}, 16'(dut.entry_q[3]), 16'(e3));
    endtask

    task automatic send(input logic is_idx, input logic [7:0] d);
        tok_valid_in    = 1'b1;
        tok_is_index_in = is_idx;
        tok_data_in     = d;
        @(posedge clk_in);
        #1;
        tok_valid_in    = 1'b0;
    endtask

`ifdef MTF_DECODE_STATS_EN
    task automatic chk_stats(input string tag, input logic [15:0] l, input logic [15:0] i,
                             input logic [15:0] e);
        chk({tag, "_lit"}, lit_cnt_out, l);
        chk({tag, "_idx"}, idx_cnt_out, i);
        chk({tag, "_err"}, err_cnt_out, e);
    endtask
`endif

    initial begin
        rst_in          = 1'b1;
        tok_valid_in    = 1'b1;
        tok_is_index_in = 1'b0;
        tok_data_in     = 8'h5A;
        data_ready_in   = 1'b0;
        #1;
        chk("ready_in_reset", 16'(tok_ready_out), 16'h0);
        @(posedge clk_in);
        #1;
        chk("rst_data", 16'(data_out), 16'h00);
        chk("rst_valid", 16'(data_out_valid), 16'h0);
        chk("rst_err", 16'(err_out), 16'h0);
        chk("rst_count", 16'(list_count_out), 16'h0);
        rst_in        = 1'b0;
        tok_valid_in  = 1'b0;
        data_ready_in = 1'b1;

        // Three literals back to back
        send(1'b0, 8'h11);
        chk("lit11_data", 16'(data_out), 16'h11);
        chk("lit11_valid", 16'(data_out_valid), 16'h1);
        chk("lit11_count", 16'(list_count_out), 16'h1);
        send(1'b0, 8'h22);
        chk("lit22_data", 16'(data_out), 16'h22);
        send(1'b0, 8'h33);
        chk("lit33_data", 16'(data_out), 16'h33);
        chk("lit33_valid", 16'(data_out_valid), 16'h1);
        chk("lit33_count", 16'(list_count_out), 16'h3);
        chk_list("list_332211", 8'h33, 8'h22, 8'h11, 8'h00);

        // Index 2 moves the oldest entry to the front
        send(1'b1, 8'h02);
        chk("idx2_data", 16'(data_out), 16'h11);
        chk("idx2_valid", 16'(data_out_valid), 16'h1);
        chk_list("list_113322", 8'h11, 8'h33, 8'h22, 8'h00);

        // Index 3 with count 3 is an error
        send(1'b1, 8'h03);
        chk("idx3_err", 16'(err_out), 16'h1);
        chk("idx3_valid", 16'(data_out_valid), 16'h0);
        chk("idx3_count", 16'(list_count_out), 16'h3);
        chk_list("list_after_err", 8'h11, 8'h33, 8'h22, 8'h00);
        @(posedge clk_in);
        #1;
        chk("err_pulse_end", 16'(err_out), 16'h0);
        chk("idle_valid", 16'(data_out_valid), 16'h0);
`ifdef MTF_DECODE_STATS_EN
        chk_stats("stats_a", 16'd3, 16'd1, 16'd1);
`endif

        // Fresh list, five unique literals saturate the count
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk("rst2_count", 16'(list_count_out), 16'h0);
        for (int b = 1; b <= 5; b++) send(1'b0, 8'(b));
        chk("lit05_data", 16'(data_out), 16'h05);
        chk("sat_count", 16'(list_count_out), 16'h4);
        chk_list("list_05040302", 8'h05, 8'h04, 8'h03, 8'h02);
        send(1'b0, 8'h02);
        chk("hit02_data", 16'(data_out), 16'h02);
        chk("hit02_count", 16'(list_count_out), 16'h4);
        chk_list("list_02050403", 8'h02, 8'h05, 8'h04, 8'h03);

        // Backpressure: output held, token stalled
        data_ready_in   = 1'b0;
        tok_valid_in    = 1'b1;
        tok_is_index_in = 1'b0;
        tok_data_in     = 8'hAA;
        #1;
        chk("stall_ready", 16'(tok_ready_out), 16'h0);
        @(posedge clk_in);
        #1;
        chk("stall1_data", 16'(data_out), 16'h02);
        chk("stall1_valid", 16'(data_out_valid), 16'h1);
        @(posedge clk_in);
        #1;
        chk("stall2_data", 16'(data_out), 16'h02);
        chk_list("list_stalled", 8'h02, 8'h05, 8'h04, 8'h03);
        data_ready_in = 1'b1;
        #1;
        chk("release_ready", 16'(tok_ready_out), 16'h1);
        @(posedge clk_in);
        #1;
        tok_valid_in = 1'b0;
        chk("release_data", 16'(data_out), 16'hAA);
        chk("release_valid", 16'(data_out_valid), 16'h1);
        chk_list("list_aa020504", 8'hAA, 8'h02, 8'h05, 8'h04);

        // Index 0 keeps the list; upper index bits are ignored
        send(1'b1, 8'hFC);
        chk("idx0_data", 16'(data_out), 16'hAA);
        chk_list("list_idx0", 8'hAA, 8'h02, 8'h05, 8'h04);
        send(1'b1, 8'hFD);
        chk("idx1_data", 16'(data_out), 16'h02);
        chk_list("list_02aa0504", 8'h02, 8'hAA, 8'h05, 8'h04);
`ifdef MTF_DECODE_STATS_EN
        chk_stats("stats_b", 16'd7, 16'd2, 16'd0);
`endif

        // Reset mid-stream with a token offered
        rst_in          = 1'b1;
        tok_valid_in    = 1'b1;
        tok_is_index_in = 1'b0;
        tok_data_in     = 8'h77;
        #1;
        chk("midrst_ready", 16'(tok_ready_out), 16'h0);
        @(posedge clk_in);
        #1;
        chk("midrst_data", 16'(data_out), 16'h00);
        chk("midrst_valid", 16'(data_out_valid), 16'h0);
        chk("midrst_err", 16'(err_out), 16'h0);
        chk("midrst_count", 16'(list_count_out), 16'h0);
        chk_list("list_midrst", 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef MTF_DECODE_STATS_EN
        chk_stats("stats_rst", 16'd0, 16'd0, 16'd0);
`endif
        rst_in = 1'b0;

        // Empty list: index 0 errors, literal 0x00 is a miss
        send(1'b1, 8'h00);
        chk("empty_idx_err", 16'(err_out), 16'h1);
        chk("empty_idx_valid", 16'(data_out_valid), 16'h0);
        send(1'b0, 8'h00);
        chk("lit00_valid", 16'(data_out_valid), 16'h1);
        chk("lit00_data", 16'(data_out), 16'h00);
        chk("lit00_count", 16'(list_count_out), 16'h1);
        chk("lit00_err", 16'(err_out), 16'h0);
`ifdef MTF_DECODE_STATS_EN
        chk_stats("stats_c", 16'd1, 16'd0, 16'd1);
`endif
        @(posedge clk_in);
        #1;
        chk("drain_valid", 16'(data_out_valid), 16'h0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
